// File: rtl/instr_encoder.sv
// RV32I instruction packer: field-level requests in, encoded words written to consecutive imem addresses.
// Optional macro INSTR_ENC_SUB_EN turns the reserved kind 11 into a SUB encoding.
module instr_encoder #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        LOAD,
        DONE,
        FULL
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    state_t            state_reg, state_next;
    logic              in_ready_reg, in_ready_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              done_reg, done_next;
    logic              full_reg, full_next;
    logic              err_reg, err_next;

    logic              xfer;
    logic              is_write;
    logic [31:0]       enc;
    logic [ADDR_W:0]   count_inc;

    always_comb begin
        is_write = 1'b1;
        enc      = 32'h0000_0013;
        case (in_kind)
            2'b00:   enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OP_REG};
            2'b01:   enc = {in_imm, in_rs1, 3'b000, in_rd, OP_IMM};
            2'b10:   enc = 32'h0000_0013;
            default: begin
`ifdef INSTR_ENC_SUB_EN
                enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OP_REG};
`else
                is_write = 1'b0;
`endif
            end
        endcase
    end

    assign xfer      = in_valid && in_ready_reg && !clear && (state_reg == LOAD);
    assign count_inc = count_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        count_next = count_reg;
        done_next  = done_reg;
        full_next  = full_reg;
        err_next   = err_reg;

        if (clear) begin
            state_next = LOAD;
            count_next = '0;
            done_next  = 1'b0;
            full_next  = 1'b0;
            err_next   = 1'b0;
        end else if (xfer) begin
            if (is_write) begin
                we_next    = 1'b1;
                addr_next  = count_reg[ADDR_W-1:0];
                wdata_next = enc;
                count_next = count_inc;
            end else begin
                err_next = 1'b1;
            end
            if (in_last) begin
                done_next  = 1'b1;
                state_next = DONE;
            end
            // Filling the memory overrides sealing; done still reports in_last.
            if (is_write && count_inc == DEPTH_C) begin
                full_next  = 1'b1;
                state_next = FULL;
            end
        end

        in_ready_next = (state_next == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= LOAD;
            in_ready_reg <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            count_reg    <= '0;
            done_reg     <= 1'b0;
            full_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= in_ready_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            count_reg    <= count_next;
            done_reg     <= done_next;
            full_reg     <= full_next;
            err_reg      <= err_next;
        end
    end

    assign in_ready   = in_ready_reg;
    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign count      = count_reg;
    assign done       = done_reg;
    assign full       = full_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [11:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              full;
    logic              err;

    int errors = 0;
    int checks = 0;
    int base;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done),
        .full       (full),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and log what the DUT now presents.
    task automatic step();
        @(posedge clk);
        #1;
        $display("txn t=%0t valid=%0b kind=%0d clear=%0b we=%0b addr=%0d wdata=0x%08h count=%0d ready=%0b done=%0b full=%0b err=%0b",
                 $time, in_valid, in_kind, clear, imem_we, imem_addr, imem_wdata, count, in_ready, done, full, err);
    endtask

    task automatic req(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [11:0] imm, input logic last);
        in_valid = 1'b1;
        in_kind  = kind;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_last  = last;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        idle();
        in_kind = 2'b00;
        in_rd = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_imm = '0;

        // Reset state
        #12;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we",    32'(imem_we),  32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata,    32'd0);
        check("rst_count", 32'(count),    32'd0);
        check("rst_flags", {29'd0, done, full, err}, 32'd0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // ADD rd=3 rs1=1 rs2=2
        req(2'b00, 5'd3, 5'd1, 5'd2, 12'h000, 1'b0);
        step();
        idle();
        check("add_we",    32'(imem_we),   32'd1);
        check("add_addr",  32'(imem_addr), 32'd0);
        check("add_wdata", imem_wdata,     32'h002081B3);
        check("add_count", 32'(count),     32'd1);

        // ADDI then NOP back to back from address 0
        do_clear();
        check("clr_count", 32'(count),   32'd0);
        check("clr_we",    32'(imem_we), 32'd0);
        req(2'b01, 5'd5, 5'd0, 5'd0, 12'hFFF, 1'b0);
        step();
        check("addi_we",    32'(imem_we),   32'd1);
        check("addi_addr",  32'(imem_addr), 32'd0);
        check("addi_wdata", imem_wdata,     32'hFFF00293);
        req(2'b10, 5'd7, 5'd9, 5'd11, 12'h5A5, 1'b0);
        step();
        idle();
        check("nop_we",    32'(imem_we),   32'd1);
        check("nop_addr",  32'(imem_addr), 32'd1);
        check("nop_wdata", imem_wdata,     32'h00000013);
        check("nop_count", 32'(count),     32'd2);
        step();
        check("idle_we",         32'(imem_we),   32'd0);
        check("idle_hold_wdata", imem_wdata,     32'h00000013);
        check("idle_hold_addr",  32'(imem_addr), 32'd1);

        // Kind 11
        req(2'b11, 5'd3, 5'd1, 5'd2, 12'h000, 1'b0);
        step();
        idle();
`ifdef INSTR_ENC_SUB_EN
        check("sub_we",    32'(imem_we),   32'd1);
        check("sub_addr",  32'(imem_addr), 32'd2);
        check("sub_wdata", imem_wdata,     32'h402081B3);
        check("sub_err",   32'(err),       32'd0);
        check("sub_count", 32'(count),     32'd3);
        base = 3;
`else
        check("rsv_we",    32'(imem_we), 32'd0);
        check("rsv_err",   32'(err),     32'd1);
        check("rsv_count", 32'(count),   32'd2);
        base = 2;
`endif

        // Program sealed by in_last on the third request
        for (int i = 0; i < 3; i++) begin
            req(2'b00, 5'd1, 5'd2, 5'd3, 12'h000, i == 2);
            step();
            check("seq_we",    32'(imem_we),   32'd1);
            check("seq_addr",  32'(imem_addr), 32'(base + i));
            check("seq_count", 32'(count),     32'(base + i + 1));
        end
        check("last_done",  32'(done),     32'd1);
        check("last_ready", 32'(in_ready), 32'd0);
        in_last = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("sealed_we",    32'(imem_we), 32'd0);
            check("sealed_count", 32'(count),   32'(base + 3));
        end

        // clear with in_valid still high
        clear = 1'b1;
        step();
        clear = 1'b0;
        idle();
        check("clr_drop_we", 32'(imem_we),  32'd0);
        check("clr_count2",  32'(count),    32'd0);
        check("clr_flags",   {29'd0, done, full, err}, 32'd0);
        check("clr_ready",   32'(in_ready), 32'd1);

        // DEPTH+2 requests held continuously
        req(2'b00, 5'd3, 5'd1, 5'd2, 12'h000, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            step();
            if (i < DEPTH) begin
                check("fill_we",    32'(imem_we),   32'd1);
                check("fill_addr",  32'(imem_addr), 32'(i));
                check("fill_wdata", imem_wdata,     32'h002081B3);
                check("fill_count", 32'(count),     32'(i + 1));
            end else begin
                check("over_we",    32'(imem_we), 32'd0);
                check("over_count", 32'(count),   32'(DEPTH));
            end
        end
        idle();
        check("full_flag",  32'(full),     32'd1);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_done",  32'(done),     32'd0);

        // Asynchronous reset while a write is pending in the output stage
        do_clear();
        req(2'b01, 5'd4, 5'd4, 5'd0, 12'h123, 1'b0);
        step();
        idle();
        check("pend_we", 32'(imem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we",    32'(imem_we),   32'd0);
        check("arst_addr",  32'(imem_addr), 32'd0);
        check("arst_wdata", imem_wdata,     32'd0);
        check("arst_count", 32'(count),     32'd0);
        check("arst_ready", 32'(in_ready),  32'd0);
        check("arst_flags", {29'd0, done, full, err}, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("arst_ready_back", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
